// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin owner selection for the shared system bus between four masters.
// Exactly one master owns the bus at any time; the owner index drives the
// master-side address/control mux. An optional hold limit forces the owner to
// give up the bus after HOLD_MAX contended cycles so a busy master cannot
// starve the others.
//
// Request/grant protocol (all signals active-low, 0 = asserted):
//   A master asserts mN_req_ and keeps it asserted while it wants the bus.
//   It may drive the bus only in cycles where it samples mN_grnt_ low. A
//   grant is a registered output, so a request first seen at one edge shows
//   up as a grant after the following edge at the earliest. A master that
//   loses its grant (release hand-over or forced rotation) stops driving on
//   the next cycle and must keep or re-assert its request to be served again.
//
// Parameters:
//   HOLD_MAX  maximum contended cycles an owner keeps the bus (0 = no limit).
//             Legal range 0..255.
//
// Ports:
//   clk                      system clock, rising-edge
//   reset_                   synchronous active-low reset
//   m0_req_ .. m3_req_       active-low bus requests
//   m0_grnt_ .. m3_grnt_     active-low bus grants, exactly one low
//   owner[1:0]               index of the granted master (mux select)
//   hold_cnt[7:0]            contended cycles held by the current owner
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   output logic [7:0] hold_cnt
);

   // What the arbiter does at the coming edge.
   typedef enum logic [1:0] {
      ACT_PARK     = 2'd0,  // nobody else wants the bus: keep owner, clear count
      ACT_HANDOVER = 2'd1,  // owner released while others wait: rotate
      ACT_FORCED   = 2'd2,  // owner hit the hold limit: rotate anyway
      ACT_HOLD     = 2'd3   // owner keeps the bus under contention: count
   } arb_action_e;

   // Last allowed value of hold_cnt before a forced rotation. Only meaningful
   // when the limit is enabled; the guard keeps the subtraction from wrapping.
   localparam logic       LIMIT_EN  = (HOLD_MAX != 0);
   localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

   logic [3:0]  req;        // active-high requests, bit n = master n
   logic [7:0]  req_dbl;
   logic [3:0]  req_rot;    // req_rot[i] = request of master (owner + i) mod 4
   logic        cur_req;
   logic        other_req;
   logic [1:0]  next_off;
   logic [1:0]  next_owner;
   logic        at_limit;
   arb_action_e action;

   logic [1:0]  owner_d;
   logic [7:0]  hold_d;

   assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

   // Rotating the request vector so that bit 0 is the current owner turns the
   // round-robin search into a fixed-priority search over bits 1..3.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[{1'b0, owner} +: 4];

   assign cur_req   = req_rot[0];
   assign other_req = |req_rot[3:1];

   always_comb begin
      next_off = 2'd3;
      if (req_rot[1]) begin
         next_off = 2'd1;
      end else if (req_rot[2]) begin
         next_off = 2'd2;
      end
   end

   // 2-bit add wraps naturally, giving (owner + offset) mod 4.
   assign next_owner = owner + next_off;

   assign at_limit = LIMIT_EN && (hold_cnt == HOLD_LAST);

   // Decision, in priority order below reset.
   always_comb begin
      action = ACT_PARK;
      if (other_req) begin
         if (!cur_req) begin
            action = ACT_HANDOVER;
         end else if (at_limit) begin
            action = ACT_FORCED;
         end else begin
            action = ACT_HOLD;
         end
      end
   end

   always_comb begin
      owner_d = owner;
      hold_d  = hold_cnt;
      case (action)
         ACT_PARK: begin
            hold_d = 8'd0;
         end
         ACT_HANDOVER,
         ACT_FORCED: begin
            owner_d = next_owner;
            hold_d  = 8'd0;
         end
         ACT_HOLD: begin
            // Saturation only matters with the limit disabled; otherwise the
            // forced rotation clears the count long before it gets here.
            hold_d = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
         end
         default: begin
            owner_d = owner;
            hold_d  = hold_cnt;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         owner    <= 2'd0;
         hold_cnt <= 8'd0;
      end else begin
         owner    <= owner_d;
         hold_cnt <= hold_d;
      end
   end

   // Grants decode straight from the owner register: glitch-free, and no path
   // from any request input to any output.
   assign m0_grnt_ = (owner != 2'd0);
   assign m1_grnt_ = (owner != 2'd1);
   assign m2_grnt_ = (owner != 2'd2);
   assign m3_grnt_ = (owner != 2'd3);

   grant_one_cold : assert property (
      @(posedge clk) $onehot(~{m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_})
   );

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single system bus between four bus masters. Each master requests with an active-low request line. The arbiter holds exactly one active-low grant at all times and outputs the current owner index, which drives the master-side address/control multiplexer upstream of the slave read-data mux. An optional hold limit stops one master from monopolising the bus while others wait.

## Interface

Parameters:
- `HOLD_MAX`, default 16: maximum consecutive cycles an owner keeps the bus while another master is requesting. 0 disables the limit. Legal range 0..255.

Ports:
- `clk`  input  1  system clock. All state updates on the rising edge.
- `reset_`  input  1  reset. Synchronous, active-low; sampled on the rising edge of `clk`.
- `m0_req_`..`m3_req_`  input  1 each  bus request from master n, active-low (`ENABLE_` = 0).
- `m0_grnt_`..`m3_grnt_`  output  1 each  bus grant to master n, active-low. Exactly one is low at all times.
- `owner`  output  2  index of the granted master. Select input of the master mux.
- `hold_cnt`  output  8  cycles the current owner has held the bus while contended. Debug/visibility.

## Operation

State:
- `owner` register, 2 bits.
- `hold_cnt` register, 8 bits.

Grant decode:
- Purely combinational from `owner`.
- `mN_grnt_` = `ENABLE_` if `owner` == N, else `DISABLE_`.

Next-owner search, evaluated every cycle:
- `cur_req` = request of the current owner is asserted.
- `other_req` = any other request is asserted.
- Search order is owner+1, owner+2, owner+3, mod 4. The first asserted request in that order is `next`.

Update rules, in priority order:
1. `reset_` low: `owner` <= 0 and `hold_cnt` <= 0.
2. `cur_req` deasserted and `other_req`: `owner` <= `next`, `hold_cnt` <= 0.
3. `cur_req` asserted and `other_req` and `HOLD_MAX` != 0 and `hold_cnt` == `HOLD_MAX`-1: forced rotation. `owner` <= `next`, `hold_cnt` <= 0.
4. `cur_req` asserted and `other_req` (no forced rotation): `hold_cnt` <= `hold_cnt`+1. The counter saturates at 255, which is only reachable when `HOLD_MAX` = 0.
5. No other request: `owner` is unchanged (bus parked on the last owner), and `hold_cnt` <= 0.

Other rules:
- When the owner has released and nobody requests, the bus parks on that owner and the grant stays asserted.
- A master must sample its grant before driving the bus. A master that loses its grant by forced rotation must stop driving on the next cycle and re-request to get back in the queue.

## Timing

- Reset values: `owner` = 0, `hold_cnt` = 0, `m0_grnt_` = 0, `m1_grnt_`..`m3_grnt_` = 1.
- Grant latency: a request at edge k, with the owner released, gives a grant visible after edge k+1. That is 1 cycle, registered.
- The hand-over takes one edge and has no dead cycle. The old grant deasserts in the same cycle the new grant asserts.
- Simultaneous release and new requests: rule 2 applies and rotation follows round-robin order from the old owner.
- Owner releases while no one requests: no change, zero latency.
- Forced rotation: with contention present from edge k, the owner holds for exactly `HOLD_MAX` cycles and loses the grant at edge k+`HOLD_MAX`.
- Reset asserted mid-transfer: on the next edge, the grant returns to master 0 regardless of requests.
- All outputs are glitch-free functions of registers. There is no combinational path from the `req_` inputs to any output.

## Test plan

- Reset: hold `reset_`=0 for 3 cycles with all requests asserted. Required: `m0_grnt_`=0, others 1, `owner`=0, `hold_cnt`=0. Release reset with only `m2_req_`=0 and `m0_req_`=1. Required: `owner`=2 after 1 edge.
- Round robin: owner 1, then 0, 2 and 3 request while 1 drops its request. Required: `owner`=2. Drop 2. Required: `owner`=3. Drop 3. Required: `owner`=0.
- Parking: owner 3 drops its request and no one requests. Required: `owner` stays 3 and `m3_grnt_` stays 0 for 10 cycles.
- Hold limit, `HOLD_MAX`=4: master 0 holds its request and master 1 requests from edge k. Required: `hold_cnt` goes 0,1,2,3, and `owner`=1 after edge k+4. `HOLD_MAX`=0 with the same stimulus: `owner` stays 0 for 300 cycles and `hold_cnt` saturates at 255.
- Mid-operation reset: owner 2 with contention and `hold_cnt`=2, then `reset_`=0 for 1 edge. Required: `owner`=0 and `hold_cnt`=0 on that edge.
- Invariant check on random requests for 10k cycles: exactly one grant is low every cycle, and the grant index always equals `owner`.
